// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory with a post-reset clear, a program write port,
// and fetches that return NOP with fault flags when the PC is misaligned or out of range.
module instr_mem_sync #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 32,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        pc,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    output logic                     misaligned,
    output logic                     out_of_range,
    output logic                     ready,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic                     prog_ack
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            r_state, w_next;
    logic [AW-1:0]     r_ptr, w_waddr, w_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_instr, w_wdata;
    logic              r_valid, r_mis, r_oor, r_ack;
    logic              w_run, w_we, w_mis, w_oor, w_hit;
    always_comb begin
        w_next = (r_state == CLEAR && r_ptr == AW'(DEPTH - 1)) ? RUN : r_state;
    end
    assign w_run   = r_state == RUN;
    assign w_we    = !w_run || prog_we;
    assign w_waddr = w_run ? prog_addr : r_ptr;
    assign w_wdata = w_run ? prog_data : NOP;
    assign w_idx   = pc[AW+1:2];
    assign w_mis   = |pc[1:0];
    // Any set bit above the word index means the full word address is past DEPTH; no wrap.
    assign w_oor   = |pc[ADDR_W-1:AW+2];
    assign w_hit   = prog_we && prog_addr == w_idx;
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_instr <= NOP;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_oor   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ptr   <= w_run ? r_ptr : r_ptr + 1'b1;
            r_valid <= w_run && fetch_req;
            r_ack   <= w_run && prog_we;
            if (w_run && fetch_req) begin
                r_mis   <= w_mis;
                r_oor   <= w_oor;
                r_instr <= (w_mis || w_oor) ? NOP : w_hit ? prog_data : r_mem[w_idx];
            end
        end
    end
    assign instr        = r_instr;
    assign instr_valid  = r_valid;
    assign misaligned   = r_mis;
    assign out_of_range = r_oor;
    assign ready        = w_run;
    assign prog_ack     = r_ack;
endmodule
